// File: rtl/mul_div_pkg.sv
// mul_div_pkg
// Shared definitions for the iterative multiply/divide unit: default operand
// width, step-counter width, op_i encodings and the control FSM state encoding.
package mul_div_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;
  localparam int CNT_WIDTH          = 6;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Division ops share the restoring datapath mode
  function automatic logic isDivOp(input op_e op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  // These ops return the upper register (product high half / remainder)
  function automatic logic isHighOp(input op_e op);
    return (op == OP_MULHU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/mul_div_datapath.sv
// mul_div_datapath
// Holds the hi (accumulator / partial remainder) and lo (multiplier /
// dividend-quotient) shift registers plus the latched second operand, and
// performs one shift-add (multiply) or shift-subtract (restoring divide)
// step per enabled cycle.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   i_load          latch operands and mode, clear hi
//   i_step          perform one iteration step
//   i_isDiv         mode to latch with the operands (1 = divide)
//   i_operandA      multiplicand / dividend
//   i_operandB      multiplier / divisor
//   o_hiNext        value hi takes after the current step
//   o_loNext        value lo takes after the current step
module mul_div_datapath
  import mul_div_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic                  i_isDiv,
  input  logic [DATA_WIDTH-1:0] i_operandA,
  input  logic [DATA_WIDTH-1:0] i_operandB,
  output logic [DATA_WIDTH-1:0] o_hiNext,
  output logic [DATA_WIDTH-1:0] o_loNext
);

  logic [DATA_WIDTH-1:0] r_hi;
  logic [DATA_WIDTH-1:0] r_lo;
  logic [DATA_WIDTH-1:0] r_opB;
  logic                  r_isDiv;

  logic [DATA_WIDTH:0]   w_mulSum;
  logic [DATA_WIDTH:0]   w_shifted;
  logic                  w_fits;
  logic [DATA_WIDTH-1:0] w_diff;

  // One iteration. Multiply: add operand B when the lsb of lo is set, then
  // shift the whole {carry, hi, lo} right so the product fills hi:lo after
  // DATA_WIDTH steps. Divide: shift the next dividend bit into the partial
  // remainder and subtract the divisor when it fits; the quotient bit enters
  // lo from the right. A zero divisor always "fits", which naturally yields an
  // all-ones quotient and leaves the dividend in the remainder.
  always_comb begin
    w_mulSum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opB} : '0);
    w_shifted = {r_hi, r_lo[DATA_WIDTH-1]};
    w_fits    = (w_shifted >= {1'b0, r_opB});
    w_diff    = w_shifted[DATA_WIDTH-1:0] - r_opB;
    if (r_isDiv) begin
      o_hiNext = w_fits ? w_diff : w_shifted[DATA_WIDTH-1:0];
      o_loNext = {r_lo[DATA_WIDTH-2:0], w_fits};
    end else begin
      o_hiNext = w_mulSum[DATA_WIDTH:1];
      o_loNext = {w_mulSum[0], r_lo[DATA_WIDTH-1:1]};
    end
  end

  // Operand/shift registers: load clears the accumulator, step advances it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_opB   <= '0;
      r_isDiv <= 1'b0;
    end else if (i_load) begin
      r_hi    <= '0;
      r_lo    <= i_operandA;
      r_opB   <= i_operandB;
      r_isDiv <= i_isDiv;
    end else if (i_step) begin
      r_hi    <= o_hiNext;
      r_lo    <= o_loNext;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit
// Iterative unsigned multiply / divide unit (one bit per cycle) with pipeline
// stall and flush handshake.
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   start_i                  request a new operation (IDLE/DONE only)
//   op_i                     00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   operand_a_i, operand_b_i multiplicand/dividend, multiplier/divisor
//   flush_i                  abort the in-flight operation
//   busy_o                   high while calculating
//   done_o                   one-cycle completion pulse
//   result_o                 registered result, held until next completion
//   stall_o                  combinational pipeline stall request
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  stall_o
);

  state_e                r_state;
  state_e                w_nextState;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_hiSelect;
  logic [DATA_WIDTH-1:0] r_result;

  op_e                   w_op;
  logic                  w_startAccept;
  logic                  w_lastStep;
  logic                  w_finish;
  logic [DATA_WIDTH-1:0] w_hiNext;
  logic [DATA_WIDTH-1:0] w_loNext;

  assign w_op          = op_e'(op_i);
  assign w_startAccept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start_i && !flush_i;
  assign w_lastStep    = (r_count == CNT_WIDTH'(DATA_WIDTH - 1));
  // The last step's outcome is captured straight from the datapath's next
  // values, so the result lands on the same edge that enters DONE.
  assign w_finish      = (r_state == ST_CALC) && !flush_i && w_lastStep;

  mul_div_datapath #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_startAccept),
    .i_step     (r_state == ST_CALC),
    .i_isDiv    (isDivOp(w_op)),
    .i_operandA (operand_a_i),
    .i_operandB (operand_b_i),
    .o_hiNext   (w_hiNext),
    .o_loNext   (w_loNext)
  );

  // Next-state and status outputs; flush beats both start and completion
  always_comb begin
    w_nextState = r_state;
    busy_o      = (r_state == ST_CALC);
    done_o      = (r_state == ST_DONE);
    // Gated by reset so an asserted start_i cannot raise stall while held in reset
    stall_o     = reset && (w_startAccept || (r_state == ST_CALC));
    case (r_state)
      ST_IDLE: if (w_startAccept) w_nextState = ST_CALC;
      ST_CALC: begin
        if (flush_i)         w_nextState = ST_IDLE;
        else if (w_lastStep) w_nextState = ST_DONE;
      end
      ST_DONE: w_nextState = w_startAccept ? ST_CALC : ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // State, step counter, result-half select and result register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_hiSelect <= 1'b0;
      r_result   <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_startAccept) begin
        r_count    <= '0;
        r_hiSelect <= isHighOp(w_op);
      end else if (r_state == ST_CALC) begin
        r_count <= r_count + 1'b1;
      end
      if (w_finish) begin
        r_result <= r_hiSelect ? w_hiNext : w_loNext;
      end
    end
  end

  assign result_o = r_result;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  request a new operation; sampled only in IDLE or DONE.
REQ-005 op_i  input  2  operation select: 00 MUL, 01 MULHU, 10 DIVU, 11 REMU.
REQ-006 operand_a_i  input  DATA_WIDTH  multiplicand / dividend.
REQ-007 operand_b_i  input  DATA_WIDTH  multiplier / divisor.
REQ-008 flush_i  input  1  abort the in-flight operation (pipeline flush on taken branch/jump).
REQ-009 busy_o  output  1  high while state is CALC.
REQ-010 done_o  output  1  one-cycle pulse; result_o valid.
REQ-011 result_o  output  DATA_WIDTH  registered result; held until the next completion.
REQ-012 stall_o  output  1  combinational pipeline stall request.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-014 IDLE or DONE with start_i=1 and flush_i=0: latch op_i and both operands, clear step counter, go to CALC.
REQ-015 CALC SHALL process one bit per cycle for exactly DATA_WIDTH cycles (6-bit counter, 0..DATA_WIDTH-1), then go to DONE.
REQ-016 Latency: start_i accepted at edge N gives done_o=1 in the cycle after edge N+DATA_WIDTH (33 cycles for 32 bits).
REQ-017 DONE SHALL last exactly one cycle; next state is CALC if a new start is accepted, else IDLE.
REQ-018 MUL SHALL return the low DATA_WIDTH bits and MULHU the high DATA_WIDTH bits of the unsigned 2*DATA_WIDTH product (shift-add).
REQ-019 DIVU SHALL return the unsigned quotient and REMU the unsigned remainder (restoring division).
REQ-020 Divisor zero: DIVU returns all ones; REMU returns the dividend; latency unchanged.
REQ-021 result_o SHALL update only on the edge entering DONE.
REQ-022 stall_o = ((IDLE or DONE) and start_i and not flush_i) or CALC; stall_o is 0 in the DONE cycle unless a new start is accepted.
REQ-023 start_i during CALC SHALL be ignored; operands are not re-latched.
REQ-024 flush_i in CALC: next state IDLE; done_o stays 0; result_o unchanged.
REQ-025 flush_i and start_i together in IDLE/DONE: flush wins; no operation starts.
REQ-026 flush_i in the DONE cycle SHALL NOT suppress done_o or result_o.

Reset
REQ-027 reset=0 SHALL force, asynchronously, state IDLE, counter 0, all internal registers 0.
REQ-028 Outputs during reset: busy_o=0, done_o=0, result_o=0, stall_o=0.
REQ-029 Reset mid-CALC SHALL discard the operation; no done_o follows reset release.
REQ-030 The first start SHALL be accepted on the first rising edge with reset=1.

Structure
REQ-031 A shared package SHALL hold the op_i encodings (MUL/MULHU/DIVU/REMU), the FSM state encoding and the DATA_WIDTH default.
REQ-032 One sub-module, mul_div_datapath, SHALL hold the accumulator/remainder and operand shift registers and perform one shift-add or shift-subtract step per enable.
REQ-033 The top level SHALL own the FSM, the counter, stall_o and the result register.

Verification
REQ-034 MUL 7*6 -> done_o in cycle 33, result_o=42; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-035 DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
REQ-036 DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234; latency 33.
REQ-037 flush_i at CALC cycle 10 -> busy_o=0 next cycle; no done_o; result_o keeps prior value. Also: flush_i with start_i in IDLE -> no start.
REQ-038 start_i pulsed in CALC cycle 5 -> ignored. start_i held through a DONE cycle -> new operation accepted; done_o pulses every 33 cycles.
REQ-039 reset=0 in CALC cycle 15 -> busy_o, stall_o, result_o go to 0 immediately; no done_o after release.
